// File: rtl/truth_table_sequencer_pkg.sv
// Purpose: shared FSM state encoding and vector-count helper for the truth-table sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t : 3-bit FSM encoding ST_IDLE..ST_DONE
//   n_vec() : number of input vectors for a given input count (2**n_in)
package truth_table_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   function automatic int n_vec(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Purpose: settle down-counter; loaded on DRIVE, counts while enabled, flags the last settle clock.
// Latency: expired is high on the SETTLE_CYCLES-th enabled cycle after load.
// Backpressure: none; load always wins over counting.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : reload the counter with SETTLE_CYCLES
//   en       : count down this cycle (FSM is in SETTLE)
//   expired  : combinational, high while enabled with one settle clock remaining
module settle_timer #(
   parameter int SETTLE_CYCLES = 2,
   localparam int CW = $clog2(SETTLE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CW'(SETTLE_CYCLES);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A count of one means this is the final settle clock, so the FSM may move to CHECK.
   assign expired = en && (cnt_q == CW'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Purpose: sweeps all 2**N_IN vectors into a combinational function, samples F, compares to a table.
// Latency: done rises N_VEC*(SETTLE_CYCLES+2) clocks after start is sampled.
// Backpressure: start is ignored while busy; expected is sampled only when a sweep starts.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (aborts any sweep)
//   start           : request a sweep from IDLE or DONE (pulse or level)
//   expected        : expected F per vector, bit i = F(i)
//   dut_in          : function inputs, MSB = first input (A)
//   dut_out         : function output F
//   busy / done     : sweep in progress / finished (held until next start or rst)
//   pass            : valid while done; 1 when no vector mismatched
//   fail_count      : number of mismatching vectors
//   first_fail_idx  : index of the first mismatch, 0 if none
//   captured        : observed F per vector
//
// Build option: STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_sequencer
   import truth_table_sequencer_pkg::*;
#(
   parameter int N_IN          = 3,
   parameter int SETTLE_CYCLES = 2,
   localparam int N_VEC        = n_vec(N_IN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_VEC-1:0] expected,
   output logic [N_IN-1:0]  dut_in,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    fail_count,
   output logic [N_IN-1:0]  first_fail_idx,
   output logic [N_VEC-1:0] captured
);

   localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);

   state_t             state_q, state_d;
   logic [N_IN-1:0]    idx_q, idx_d;
   logic [N_VEC-1:0]   exp_q, exp_d;
   logic [N_IN-1:0]    dut_in_q, dut_in_d;
   logic [N_IN:0]      fail_count_q, fail_count_d;
   logic [N_IN-1:0]    first_fail_idx_q, first_fail_idx_d;
   logic [N_VEC-1:0]   captured_q, captured_d;

   logic timer_load;
   logic timer_en;
   logic timer_expired;
   logic mismatch;

   assign timer_en = (state_q == ST_SETTLE);

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .en      (timer_en),
      .expired (timer_expired)
   );

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      exp_d            = exp_q;
      dut_in_d         = dut_in_q;
      fail_count_d     = fail_count_q;
      first_fail_idx_d = first_fail_idx_q;
      captured_d       = captured_q;
      timer_load       = 1'b0;
      mismatch         = (dut_out != exp_q[idx_q]);

      case (state_q)
         // DONE restarts exactly like IDLE; leaving DONE drops done on the same edge.
         ST_IDLE, ST_DONE: begin
            if (start) begin
               exp_d            = expected;
               fail_count_d     = '0;
               first_fail_idx_d = '0;
               captured_d       = '0;
               idx_d            = '0;
               state_d          = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            dut_in_d   = idx_q;
            timer_load = 1'b1;
            state_d    = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (timer_expired) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            // dut_out is only looked at here, so settle-time glitches never reach the results.
            captured_d[idx_q] = dut_out;
            if (mismatch) begin
               fail_count_d = fail_count_q + (N_IN+1)'(1);
               if (fail_count_q == '0) begin
                  first_fail_idx_d = idx_q;
               end
            end
`ifdef STOP_ON_FAIL_EN
            if (mismatch || (idx_q == LAST_IDX)) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + N_IN'(1);
               state_d = ST_DRIVE;
            end
`else
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + N_IN'(1);
               state_d = ST_DRIVE;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         idx_q            <= '0;
         exp_q            <= '0;
         dut_in_q         <= '0;
         fail_count_q     <= '0;
         first_fail_idx_q <= '0;
         captured_q       <= '0;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         exp_q            <= exp_d;
         dut_in_q         <= dut_in_d;
         fail_count_q     <= fail_count_d;
         first_fail_idx_q <= first_fail_idx_d;
         captured_q       <= captured_d;
      end
   end

   // Status is decoded straight from the state so reset clears it with no extra flops.
   assign busy           = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign done           = (state_q == ST_DONE);
   assign pass           = done && (fail_count_q == '0);
   assign dut_in         = dut_in_q;
   assign fail_count     = fail_count_q;
   assign first_fail_idx = first_fail_idx_q;
   assign captured       = captured_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Purpose: directed bench for truth_table_sequencer driving the function F = A | B | ~C.
// Latency: checks done timing edge by edge against N_VEC*(SETTLE_CYCLES+2).
// Backpressure: exercises start re-pulses while busy and restarts from DONE.
module tb_truth_table_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] expected;
   logic [2:0] dut_in;
   logic       dut_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_count;
   logic [2:0] first_fail_idx;
   logic [7:0] captured;

   int passed = 0;
   int total  = 0;

`ifdef STOP_ON_FAIL_EN
   localparam int FF_DONE_AT = 8;
   localparam logic [7:0] FF_CAPTURED = 8'h01;
`else
   localparam int FF_DONE_AT = 32;
   localparam logic [7:0] FF_CAPTURED = 8'hFD;
`endif

   // Function under test: A = dut_in[2], B = dut_in[1], C = dut_in[0]; correct table is 8'hFD.
   assign dut_out = dut_in[2] | dut_in[1] | ~dut_in[0];

   truth_table_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .expected       (expected),
      .dut_in         (dut_in),
      .dut_out        (dut_out),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail_count     (fail_count),
      .first_fail_idx (first_fail_idx),
      .captured       (captured)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   // Starts a sweep (start sampled at edge 0), then checks dut_in stepping and done timing
   // at every edge up to done_at. A nonzero repulse_at re-asserts start mid-sweep with a
   // different table, which must be ignored.
   task automatic sweep(input logic [7:0] exp_v, input int repulse_at, input int done_at);
      @(negedge clk);
      expected = exp_v;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      expected = 8'h00;
      chk("busy_after_start", busy, 1);
      chk("done_cleared", done, 0);
      for (int k = 1; k <= done_at; k++) begin
         @(negedge clk);
         if (k == repulse_at) begin
            start    = 1'b1;
            expected = 8'hFF;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         chk("dut_in_step", dut_in, (k - 1) / 4);
         chk("done_timing", done, k == done_at);
      end
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      expected = 8'h00;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_fail_count", fail_count, 0);
      chk("rst_first_fail", first_fail_idx, 0);
      chk("rst_captured", captured, 0);
      chk("rst_dut_in", dut_in, 0);
      @(negedge clk);
      rst = 1'b0;

      // Correct table, with an ignored start re-pulse at clock 10.
      sweep(8'hFD, 10, 32);
      chk("fd_pass", pass, 1);
      chk("fd_fail_count", fail_count, 0);
      chk("fd_first_fail", first_fail_idx, 0);
      chk("fd_captured", captured, 8'hFD);
      chk("fd_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("fd_done_held", done, 1);
      chk("fd_dut_in_held", dut_in, 7);

      // Restart from DONE with a table wrong only at vector 1; prior results must not carry over.
      sweep(8'hFF, 0, FF_DONE_AT);
      chk("ff_pass", pass, 0);
      chk("ff_fail_count", fail_count, 1);
      chk("ff_first_fail", first_fail_idx, 1);
      chk("ff_captured", captured, FF_CAPTURED);

`ifndef STOP_ON_FAIL_EN
      // Table wrong at every vector.
      sweep(8'h02, 0, 32);
      chk("x02_pass", pass, 0);
      chk("x02_fail_count", fail_count, 8);
      chk("x02_first_fail", first_fail_idx, 0);
      chk("x02_captured", captured, 8'hFD);
`endif

      // Asynchronous reset in the SETTLE phase of vector 3.
      @(negedge clk);
      expected = 8'hFD;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy, 1);
      chk("pre_rst_captured", captured, 8'h05);
      #1 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_pass", pass, 0);
      chk("arst_fail_count", fail_count, 0);
      chk("arst_first_fail", first_fail_idx, 0);
      chk("arst_captured", captured, 0);
      chk("arst_dut_in", dut_in, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_after_rst", busy, 0);

      sweep(8'hFD, 0, 32);
      chk("post_rst_pass", pass, 1);
      chk("post_rst_fail_count", fail_count, 0);
      chk("post_rst_captured", captured, 8'hFD);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
